// File: rtl/antirrebote_boton_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote_boton_pkg
//  Purpose  : Shared debounce FSM encoding and default confirmation length.
//  Revision : 1.0
// ============================================================================
package antirrebote_boton_pkg;

    // 10 ms at 50 MHz; every button input uses the same default
    localparam int unsigned c_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/antirrebote_boton_if.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote_boton_if
//  Purpose  : Raw button input and cleaned button outputs.
//  Revision : 1.0
// ============================================================================
interface antirrebote_boton_if;

    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface
`default_nettype wire

// File: rtl/antirrebote_boton_sincronizador_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sincronizador_2ff
//  Purpose  : Two-flop synchronizer for a single asynchronous pad input.
//  Revision : 1.0
// ============================================================================
module sincronizador_2ff (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule
`default_nettype wire

// File: rtl/antirrebote_boton.sv
`default_nettype none
// ============================================================================
//  Module   : antirrebote_boton
//  Purpose  : Push-button debouncer with clean level and press/release pulses.
//  Revision : 1.0
// ============================================================================
module antirrebote_boton
    import antirrebote_boton_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    antirrebote_boton_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             w_sync;
    estado_t          r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_level,   w_level_nxt;
    logic             r_press,   w_press_nxt;
    logic             r_release, w_release_nxt;

    sincronizador_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.btn_raw),
        .o_q   (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Counter restarts on every state change, so it never needs to saturate
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) begin
                    w_state_nxt = ST_WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt = ST_WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;

endmodule
`default_nettype wire
